// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit execute stage: ALU opcodes,
// flag bit positions and the two-pass sequencing states.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    ADC   = 4'd1,
    SUB   = 4'd2,
    SBB   = 4'd3,
    INC   = 4'd4,
    DEC   = 4'd5,
    CMP   = 4'd6,
    ADD16 = 4'd8,
    SUB16 = 4'd9
  } alu_op_e;

  localparam int FN = 3;
  localparam int FV = 2;
  localparam int FZ = 1;
  localparam int FC = 0;

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } exec_state_e;

  // {N,V,Z,C} from the top adder pass; zero is supplied by the caller
  // because it spans the whole result (8 or 16 bits).
  function automatic logic [3:0] calc_flags(input logic [7:0] sum,
                                            input logic       cout,
                                            input logic       a_msb,
                                            input logic       b_msb,
                                            input logic       zero);
    logic [3:0] f;
    f     = '0;
    f[FN] = sum[7];
    f[FV] = (a_msb == b_msb) && (sum[7] != a_msb);
    f[FZ] = zero;
    f[FC] = cout;
    return f;
  endfunction

endpackage

// File: rtl/adder_8.sv
// 8-bit ripple adder shared by both passes of the execute stage.
// Carry-in enters at bit 0 so ADC/SBB/SUB and the high pass of 16-bit ops work.
module adder_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [8:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};
  assign sum_o  = full[7:0];
  assign cout_o = full[8];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: decodes the ALU op, drives the shared 8-bit adder, and
// registers result and NZVC flags; 16-bit ops take a second (HI) pass.
//
// state | meaning
// IDLE  | ready for a new op (subject to output backpressure)
// HI    | high byte of ADD16/SUB16 in flight, low half latched
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  in_ah,
  input  logic [7:0]  in_bh,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic [3:0]  flags,
  input  logic        flag_we,
  input  logic [3:0]  flag_wdata
);

  exec_state_e state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_res_q, out_res_d;
  logic [3:0]  flags_q, flags_d;
  logic [7:0]  lo_q, lo_d;
  logic        cout_lo_q, cout_lo_d;
  logic [7:0]  ah_q, ah_d;
  logic [7:0]  bh_q, bh_d;

  alu_op_e     op;
  logic [7:0]  dec_b;
  logic        dec_cin;
  logic        dec_legal;
  logic        dec_wide;
  logic        dec_pass_a;

  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        accept;

  assign op = alu_op_e'(in_op);

  always_comb begin
    dec_b      = in_b;
    dec_cin    = 1'b0;
    dec_legal  = 1'b1;
    dec_wide   = 1'b0;
    dec_pass_a = 1'b0;
    case (op)
      ADD:   ;
      ADC:   dec_cin = flags_q[FC];
      SUB:   begin dec_b = ~in_b; dec_cin = 1'b1; end
      CMP:   begin dec_b = ~in_b; dec_cin = 1'b1; dec_pass_a = 1'b1; end
      SBB:   begin dec_b = ~in_b; dec_cin = flags_q[FC]; end
      INC:   begin dec_b = 8'h00; dec_cin = 1'b1; end
      DEC:   dec_b = 8'hFF;
      ADD16: dec_wide = 1'b1;
      SUB16: begin dec_b = ~in_b; dec_cin = 1'b1; dec_wide = 1'b1; end
      default: begin dec_legal = 1'b0; dec_pass_a = 1'b1; end
    endcase
  end

  // The adder serves the low/8-bit pass in IDLE and the high pass in HI.
  always_comb begin
    if (state_q == HI) begin
      add_a   = ah_q;
      add_b   = bh_q;
      add_cin = cout_lo_q;
    end else begin
      add_a   = in_a;
      add_b   = dec_b;
      add_cin = dec_cin;
    end
  end

  adder_8 u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_res_d   = out_res_q;
    flags_d     = flags_q;
    lo_d        = lo_q;
    cout_lo_d   = cout_lo_q;
    ah_d        = ah_q;
    bh_d        = bh_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_wide) begin
            state_d   = HI;
            lo_d      = add_sum;
            cout_lo_d = add_cout;
            ah_d      = in_ah;
            bh_d      = (op == SUB16) ? ~in_bh : in_bh;
          end else begin
            out_valid_d = 1'b1;
            out_res_d   = dec_pass_a ? {8'h00, in_a} : {8'h00, add_sum};
            if (dec_legal)
              flags_d = calc_flags(add_sum, add_cout, add_a[7], add_b[7],
                                   add_sum == 8'h00);
          end
        end
      end
      HI: begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_res_d   = {add_sum, lo_q};
        flags_d     = calc_flags(add_sum, add_cout, add_a[7], add_b[7],
                                 {add_sum, lo_q} == 16'h0000);
      end
      default: state_d = IDLE;
    endcase
    if (flag_we)
      flags_d = flag_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_res_q   <= 16'h0000;
      flags_q     <= FLAG_RST;
      lo_q        <= 8'h00;
      cout_lo_q   <= 1'b0;
      ah_q        <= 8'h00;
      bh_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      flags_q     <= flags_d;
      lo_q        <= lo_d;
      cout_lo_q   <= cout_lo_d;
      ah_q        <= ah_d;
      bh_q        <= bh_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with hand-computed expected values.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [7:0]  in_a, in_b, in_ah, in_bh;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [3:0]  flags;
  logic        flag_we;
  logic [3:0]  flag_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_stage #(.FLAG_RST(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ah      (in_ah),
    .in_bh      (in_bh),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .flags      (flags),
    .flag_we    (flag_we),
    .flag_wdata (flag_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an op, wait (bounded) for in_ready, return just after the accept edge.
  task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ah, input logic [7:0] bh);
    int n;
    in_op = op; in_a = a; in_b = b; in_ah = ah; in_bh = bh;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout op=%0d in_ready=%b required 1", op, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flag_we = 1'b0; flag_wdata = 4'h0;
    in_op = 4'h0; in_a = 8'h00; in_b = 8'h00; in_ah = 8'h00; in_bh = 8'h00;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b req 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b req 0", out_valid); end
    n_checks++; if (out_res !== 16'h0000) begin n_fail++; $display("FAIL rst_out_res got %h req 0000", out_res); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got %b req 0000", flags); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b req 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    drive_op(4'd0, 8'h7F, 8'h01, 8'h00, 8'h00);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b req 1", out_valid); end
    n_checks++; if (out_res !== 16'h0080) begin n_fail++; $display("FAIL add_res got %h req 0080", out_res); end
    n_checks++; if (flags !== 4'b1100) begin n_fail++; $display("FAIL add_flags got %b req 1100", flags); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop got %b req 0", out_valid); end
  endtask

  task automatic test_flag_we_adc();
    flag_we = 1'b1; flag_wdata = 4'b0001;
    tick();
    flag_we = 1'b0;
    n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL sec_flags got %b req 0001", flags); end
    drive_op(4'd1, 8'h10, 8'h20, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h0031) begin n_fail++; $display("FAIL adc_res got %h req 0031", out_res); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL adc_flags got %b req 0000", flags); end
  endtask

  task automatic test_sub();
    drive_op(4'd2, 8'h05, 8'h05, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h0000) begin n_fail++; $display("FAIL sub_eq_res got %h req 0000", out_res); end
    n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL sub_eq_flags got %b req 0011", flags); end
    drive_op(4'd2, 8'h00, 8'h01, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h00FF) begin n_fail++; $display("FAIL sub_borrow_res got %h req 00ff", out_res); end
    n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL sub_borrow_flags got %b req 1000", flags); end
  endtask

  task automatic test_back_to_back();
    drive_op(4'd0, 8'hFF, 8'h01, 8'h00, 8'h00);
    n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL wrap_flags got %b req 0011", flags); end
    drive_op(4'd1, 8'h00, 8'h00, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h0001) begin n_fail++; $display("FAIL b2b_adc_res got %h req 0001", out_res); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_adc_flags got %b req 0000", flags); end
  endtask

  task automatic test_misc_ops();
    drive_op(4'd6, 8'h03, 8'h05, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h0003) begin n_fail++; $display("FAIL cmp_res got %h req 0003", out_res); end
    n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL cmp_flags got %b req 1000", flags); end
    drive_op(4'd4, 8'hFF, 8'h55, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h0000) begin n_fail++; $display("FAIL inc_res got %h req 0000", out_res); end
    n_checks++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL inc_flags got %b req 0011", flags); end
    drive_op(4'd5, 8'h00, 8'h55, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h00FF) begin n_fail++; $display("FAIL dec_res got %h req 00ff", out_res); end
    n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL dec_flags got %b req 1000", flags); end
    drive_op(4'd7, 8'h5A, 8'h11, 8'h00, 8'h00);
    n_checks++; if (out_res !== 16'h005A) begin n_fail++; $display("FAIL illegal_res got %h req 005a", out_res); end
    n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL illegal_flags got %b req 1000", flags); end
  endtask

  task automatic test_wide();
    drive_op(4'd8, 8'hFF, 8'h01, 8'h00, 8'h00);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add16_hi_ready got %b req 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add16_hi_valid got %b req 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add16_valid got %b req 1", out_valid); end
    n_checks++; if (out_res !== 16'h0100) begin n_fail++; $display("FAIL add16_res got %h req 0100", out_res); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL add16_flags got %b req 0000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add16_ready_back got %b req 1", in_ready); end
    drive_op(4'd9, 8'h34, 8'h35, 8'h12, 8'h02);
    tick();
    n_checks++; if (out_res !== 16'h0FFF) begin n_fail++; $display("FAIL sub16_res got %h req 0fff", out_res); end
    n_checks++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL sub16_flags got %b req 0001", flags); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive_op(4'd0, 8'h01, 8'h02, 8'h00, 8'h00);
    in_op = 4'd0; in_a = 8'h10; in_b = 8'h10; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_res !== 16'h0003) begin n_fail++; $display("FAIL stall_res cyc %0d got v=%b %h req v=1 0003", i, out_valid, out_res); end
      n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL stall_flags cyc %0d got %b req 0000", i, flags); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready cyc %0d got %b req 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b req 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_res !== 16'h0020) begin n_fail++; $display("FAIL release_next got v=%b %h req v=1 0020", out_valid, out_res); end
    tick();
  endtask

  task automatic test_reset_mid_hi();
    flag_we = 1'b1; flag_wdata = 4'b1111;
    tick();
    flag_we = 1'b0;
    drive_op(4'd9, 8'h10, 8'h01, 8'h20, 8'h01);
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midhi_rst_valid got %b req 0", out_valid); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL midhi_rst_flags got %b req 0000", flags); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midhi_rst_ready got %b req 0", in_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midhi_ghost cyc %0d got %b req 0", i, out_valid); end
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midhi_idle_ready got %b req 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_flag_we_adc();
    test_sub();
    test_back_to_back();
    test_misc_ops();
    test_wide();
    test_stall();
    test_reset_mid_hi();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
